// File: rtl/rx_uart_cfg.sv
// Configurable UART receiver: 2-flop synchroniser, 3-sample majority bit decision,
// runtime baud divisor, optional parity, 1/2 stop bits, show-ahead output FIFO.
module rx_uart_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_i,
  input  logic                 en_i,
  input  logic [DIV_W-1:0]     baud_div_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_perr_o,
  output logic                 rx_ferr_o,
  output logic                 rx_vld_o,
  input  logic                 rx_rdy_i,
  output logic                 overrun_o,
  input  logic                 clr_i,
  output logic                 rts_n_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_BITS);
  localparam int EW = DATA_BITS + 2;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_PUSH} state_t;

  state_t               state;
  logic                 rx_m, rxs, rxs_d;
  logic [DIV_W-1:0]     div_q, bc, half;
  logic                 smp0, smp1;
  logic [DATA_BITS-1:0] shreg;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic                 perr, ferr;
  logic                 at_s0, at_s1, at_dec, wrap, maj, fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m  <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      rx_m  <= rx_i;
      rxs   <= rx_m;
      rxs_d <= rxs;
    end
  end

  always_comb begin
    half   = div_q >> 1;
    at_s0  = (bc == half - DIV_W'(1));
    at_s1  = (bc == half);
    at_dec = (bc == half + DIV_W'(1));
    wrap   = (bc == div_q - DIV_W'(1));
    maj    = (smp0 & smp1) | (smp0 & rxs) | (smp1 & rxs);
    fall   = rxs_d & ~rxs & en_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      bc       <= '0;
      div_q    <= '0;
      smp0     <= 1'b1;
      smp1     <= 1'b1;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else if (!en_i) begin
      state <= S_IDLE;
    end else begin
      if (at_s0) smp0 <= rxs;
      if (at_s1) smp1 <= rxs;
      bc <= wrap ? '0 : bc + DIV_W'(1);
      case (state)
        S_IDLE: begin
          bc <= '0;
          if (fall) begin
            state    <= S_START;
            div_q    <= baud_div_i;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
          end
        end
        S_START: begin
          if (at_dec && maj) state <= S_IDLE;
          else if (wrap)     state <= S_DATA;
        end
        S_DATA: begin
          // LSB-first shift: after DATA_BITS shifts the first bit sits at position 0
          if (at_dec) shreg <= {maj, shreg[DATA_BITS-1:1]};
          if (wrap) begin
            if (bit_idx == BW'(DATA_BITS - 1)) state <= (PARITY != 0) ? S_PARITY : S_STOP;
            else bit_idx <= bit_idx + BW'(1);
          end
        end
        S_PARITY: begin
          if (at_dec) perr <= (^shreg) ^ maj ^ (PARITY == 2);
          if (wrap)   state <= S_STOP;
        end
        S_STOP: begin
          // last stop decision pushes immediately so the next start edge is not missed
          if (at_dec) begin
            if (!maj) ferr <= 1'b1;
            if (stop_idx == 1'(STOP_BITS - 1)) state <= S_PUSH;
          end else if (wrap) begin
            stop_idx <= 1'b1;
          end
        end
        S_PUSH:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt, cnt_nxt;
  logic          push, pop, full, push_ok;

  always_comb begin
    push    = (state == S_PUSH) && en_i;
    pop     = (cnt != '0) && rx_rdy_i;
    full    = (cnt == (AW+1)'(FIFO_DEPTH));
    push_ok = push && (!full || pop);
    cnt_nxt = cnt + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= {perr, ferr, shreg};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp        <= '0;
      rp        <= '0;
      cnt       <= '0;
      overrun_o <= 1'b0;
      rts_n_o   <= 1'b1;
    end else begin
      if (push_ok) wp <= wp + AW'(1);
      if (pop)     rp <= rp + AW'(1);
      cnt <= cnt_nxt;
      if (push && full && !pop) overrun_o <= 1'b1;
      else if (clr_i)           overrun_o <= 1'b0;
      rts_n_o <= (cnt_nxt > (AW+1)'(FIFO_DEPTH - 2));
    end
  end

  // head is masked while empty so the outputs read zero after reset
  always_comb begin
    rx_vld_o = (cnt != '0);
    {rx_perr_o, rx_ferr_o, rx_data_o} = rx_vld_o ? mem[rp] : '0;
  end

endmodule

// File: tb/tb_rx_uart_cfg.sv
// Bench for rx_uart_cfg: 8N1, even-parity and odd-parity/2-stop instances,
// scoreboard queues filled when frames are sent and drained as words appear.
module tb_rx_uart_cfg;

  localparam int D = 16;

  logic        clk = 1'b0;
  logic        rst, en, clr;
  logic [15:0] baud;
  logic        rx0, rx1, rx2, rdy0, rdy1, rdy2;
  logic [7:0]  data0, data1, data2;
  logic        perr0, perr1, perr2, ferr0, ferr1, ferr2;
  logic        vld0, vld1, vld2, ovr0, ovr1, ovr2, rts0, rts1, rts2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int vld0_rise = -1;
  logic vld0_q = 1'b0;
  logic [9:0] q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (vld0 && !vld0_q) vld0_rise <= cyc;
    vld0_q <= vld0;
  end

  rx_uart_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DIV_W(16), .FIFO_DEPTH(4)) u_dut0 (
    .clk(clk), .rst(rst), .rx_i(rx0), .en_i(en), .baud_div_i(baud),
    .rx_data_o(data0), .rx_perr_o(perr0), .rx_ferr_o(ferr0), .rx_vld_o(vld0),
    .rx_rdy_i(rdy0), .overrun_o(ovr0), .clr_i(clr), .rts_n_o(rts0));

  rx_uart_cfg #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .DIV_W(16), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .rst(rst), .rx_i(rx1), .en_i(en), .baud_div_i(baud),
    .rx_data_o(data1), .rx_perr_o(perr1), .rx_ferr_o(ferr1), .rx_vld_o(vld1),
    .rx_rdy_i(rdy1), .overrun_o(ovr1), .clr_i(clr), .rts_n_o(rts1));

  rx_uart_cfg #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .DIV_W(16), .FIFO_DEPTH(4)) u_dut2 (
    .clk(clk), .rst(rst), .rx_i(rx2), .en_i(en), .baud_div_i(baud),
    .rx_data_o(data2), .rx_perr_o(perr2), .rx_ferr_o(ferr2), .rx_vld_o(vld2),
    .rx_rdy_i(rdy2), .overrun_o(ovr2), .clr_i(clr), .rts_n_o(rts2));

  task automatic set_rx(input int which, input logic v);
    case (which)
      0: rx0 = v;
      1: rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic set_rdy(input int which, input logic v);
    case (which)
      0: rdy0 = v;
      1: rdy1 = v;
      default: rdy2 = v;
    endcase
  endtask

  function automatic logic [10:0] head(input int which);
    case (which)
      0: return {vld0, perr0, ferr0, data0};
      1: return {vld1, perr1, ferr1, data1};
      default: return {vld2, perr2, ferr2, data2};
    endcase
  endfunction

  // Frame bits are held D cycles each; gbit/goff invert the line for one cycle.
  task automatic send_frame(input int which, input logic [7:0] d, input int npar,
                            input logic pbit, input int nstop, input logic stopv,
                            input int gbit, input int goff);
    logic [11:0] bits;
    int n;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    n = 9;
    if (npar != 0) begin bits[n] = pbit; n++; end
    for (int s = 0; s < nstop; s++) begin bits[n] = stopv; n++; end
    for (int j = 0; j < n; j++)
      for (int k = 0; k < D; k++) begin
        set_rx(which, (j == gbit && k == goff) ? ~bits[j] : bits[j]);
        @(negedge clk);
      end
  endtask

  task automatic drain(input int which, input string name);
    logic [9:0]  exp;
    logic [10:0] h;
    int t;
    t = 0;
    h = head(which);
    while (!h[10] && t < 20*D) begin @(negedge clk); t++; h = head(which); end
    exp = '0;
    case (which)
      0: if (q0.size() != 0) exp = q0.pop_front();
      1: if (q1.size() != 0) exp = q1.pop_front();
      default: if (q2.size() != 0) exp = q2.pop_front();
    endcase
    checks++;
    if (!h[10]) begin
      failures++;
      $display("FAIL %s: rx_vld_o stayed 0, expected word %h", name, exp);
    end else if (h[9:0] !== exp) begin
      failures++;
      $display("FAIL %s: {perr,ferr,data}=%h expected %h", name, h[9:0], exp);
    end
    set_rdy(which, 1'b1);
    @(negedge clk);
    set_rdy(which, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; clr = 1'b0; baud = 16'(D);
    rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1; rdy0 = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({vld0, perr0, ferr0, data0, ovr0, rts0} !== 13'h001) begin
      failures++;
      $display("FAIL reset_state: {vld,perr,ferr,data,ovr,rts}=%h expected 001", {vld0, perr0, ferr0, data0, ovr0, rts0});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rts0 !== 1'b0) begin failures++; $display("FAIL reset_rts_release: rts_n_o=%b expected 0", rts0); end
  endtask

  task automatic test_basic();
    int s0, exp_rise;
    s0 = cyc;
    q0.push_back({2'b00, 8'hA5});
    send_frame(0, 8'hA5, 0, 1'b0, 1, 1'b1, -1, 0);
    // 2 sync flops + edge detect, 9 full bits, stop decision at H+1, PUSH, then visible
    exp_rise = s0 + 3 + 9*D + D/2 + 3;
    checks++;
    if (vld0_rise !== exp_rise) begin
      failures++;
      $display("FAIL basic_latency: rx_vld_o rose at cycle %0d expected %0d", vld0_rise, exp_rise);
    end
    drain(0, "basic_A5");
    checks++;
    if (vld0 !== 1'b0) begin failures++; $display("FAIL basic_pop: rx_vld_o=%b expected 0", vld0); end
  endtask

  task automatic test_back_to_back();
    q0.push_back({2'b00, 8'h5A});
    q0.push_back({2'b00, 8'hC3});
    send_frame(0, 8'h5A, 0, 1'b0, 1, 1'b1, -1, 0);
    send_frame(0, 8'hC3, 0, 1'b0, 1, 1'b1, -1, 0);
    drain(0, "b2b_first");
    drain(0, "b2b_second");
  endtask

  task automatic test_parity();
    q1.push_back({2'b10, 8'h03});
    send_frame(1, 8'h03, 1, 1'b1, 1, 1'b1, -1, 0);
    drain(1, "even_bad");
    q1.push_back({2'b00, 8'h03});
    send_frame(1, 8'h03, 1, 1'b0, 1, 1'b1, -1, 0);
    drain(1, "even_good");
    q2.push_back({2'b00, 8'h03});
    send_frame(2, 8'h03, 1, 1'b1, 2, 1'b1, -1, 0);
    drain(2, "odd_good");
    q2.push_back({2'b10, 8'h03});
    send_frame(2, 8'h03, 1, 1'b0, 2, 1'b1, -1, 0);
    drain(2, "odd_bad");
  endtask

  task automatic test_framing();
    q0.push_back({2'b01, 8'h5A});
    q0.push_back({2'b00, 8'h11});
    send_frame(0, 8'h5A, 0, 1'b0, 1, 1'b0, -1, 0);
    repeat (40) @(negedge clk);
    set_rx(0, 1'b1);
    repeat (2*D) @(negedge clk);
    send_frame(0, 8'h11, 0, 1'b0, 1, 1'b1, -1, 0);
    drain(0, "ferr_word");
    drain(0, "after_break");
  endtask

  task automatic test_glitch();
    set_rx(0, 1'b0);
    repeat (5) @(negedge clk);
    set_rx(0, 1'b1);
    repeat (12*D) @(negedge clk);
    checks++;
    if ({vld0, ovr0} !== 2'b00) begin
      failures++;
      $display("FAIL start_glitch: {vld,ovr}=%b expected 00", {vld0, ovr0});
    end
    q0.push_back({2'b00, 8'h3C});
    send_frame(0, 8'h3C, 0, 1'b0, 1, 1'b1, 3, 2);
    drain(0, "glitch_outside");
    q0.push_back({2'b00, 8'hC3});
    send_frame(0, 8'hC3, 0, 1'b0, 1, 1'b1, 5, 9);
    drain(0, "glitch_one_sample");
  endtask

  task automatic test_fifo_full();
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) q0.push_back({2'b00, 8'(i)});
      send_frame(0, 8'(i), 0, 1'b0, 1, 1'b1, -1, 0);
      if (i == 2) begin
        checks++;
        if (rts0 !== 1'b0) begin failures++; $display("FAIL rts_two_words: rts_n_o=%b expected 0", rts0); end
      end
      if (i == 3) begin
        checks++;
        if (rts0 !== 1'b1) begin failures++; $display("FAIL rts_three_words: rts_n_o=%b expected 1", rts0); end
      end
      if (i == 4) begin
        checks++;
        if (ovr0 !== 1'b0) begin failures++; $display("FAIL ovr_at_full: overrun_o=%b expected 0", ovr0); end
      end
    end
    checks++;
    if (ovr0 !== 1'b1) begin failures++; $display("FAIL ovr_set: overrun_o=%b expected 1", ovr0); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (ovr0 !== 1'b0) begin failures++; $display("FAIL ovr_clear: overrun_o=%b expected 0", ovr0); end
    for (int i = 0; i < 4; i++) drain(0, "fifo_drain");
    checks++;
    if ({vld0, rts0} !== 2'b00) begin
      failures++;
      $display("FAIL fifo_empty: {vld,rts_n}=%b expected 00", {vld0, rts0});
    end
  endtask

  task automatic test_abort();
    send_frame(0, 8'h77, 0, 1'b0, 1, 1'b1, -1, 0);
    checks++;
    if (vld0 !== 1'b1) begin failures++; $display("FAIL abort_prefill: rx_vld_o=%b expected 1", vld0); end
    set_rx(0, 1'b0);
    repeat (D) @(negedge clk);
    set_rx(0, 1'b1);
    repeat (3*D + 4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({vld0, perr0, ferr0, data0, ovr0, rts0} !== 13'h001) begin
      failures++;
      $display("FAIL midframe_reset: {vld,perr,ferr,data,ovr,rts}=%h expected 001", {vld0, perr0, ferr0, data0, ovr0, rts0});
    end
    rst = 1'b0;
    repeat (12*D) @(negedge clk);
    checks++;
    if (vld0 !== 1'b0) begin failures++; $display("FAIL reset_no_word: rx_vld_o=%b expected 0", vld0); end
    q0.push_back({2'b00, 8'h3C});
    send_frame(0, 8'h3C, 0, 1'b0, 1, 1'b1, -1, 0);
    drain(0, "after_reset");
    set_rx(0, 1'b0);
    repeat (D + D/2) @(negedge clk);
    en = 1'b0;
    set_rx(0, 1'b1);
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (12*D) @(negedge clk);
    checks++;
    if (vld0 !== 1'b0) begin failures++; $display("FAIL enable_discard: rx_vld_o=%b expected 0", vld0); end
    q0.push_back({2'b00, 8'hA5});
    send_frame(0, 8'hA5, 0, 1'b0, 1, 1'b1, -1, 0);
    drain(0, "after_enable");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_parity();
    test_framing();
    test_glitch();
    test_fifo_full();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
